// File: rtl/gen_test_pulse_cfg_seq.sv
// gen_test_pulse_cfg_seq: AXI4-Lite master that programs up to four
// pulse-generator registers, with optional readback compare.
module gen_test_pulse_cfg_seq #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h0000_0000,
  parameter int C_NUM_REGS = 4,
  parameter int C_TIMEOUT = 255
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          start,
  input  logic                          verify_en,
  input  logic [127:0]                  cfg_data,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    err_code,
  output logic [1:0]                    err_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [1:0] LAST = 2'(C_NUM_REGS - 1);
  localparam logic [31:0] TMO = 32'(C_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, WR, WRESP, RD, RDATA, NEXT, FIN
  } state_t;

  state_t          state, state_n;
  logic [1:0]      idx, idx_n;
  logic [127:0]    cfg_q, cfg_src;
  logic            ver_q;
  logic            awvalid_q, wvalid_q, arvalid_q;
  logic [AW-1:0]   awaddr_q, araddr_q, addr_n;
  logic [DW-1:0]   wdata_q;
  logic [31:0]     word_n, tmo_cnt;
  logic            err_set;
  logic [1:0]      err_n;
  logic            aw_ok, w_ok, tmo_hit;
  logic            wr_entry, rd_entry, wait_st;

  // The first word comes straight from cfg_data since cfg_q loads
  // on the same edge that enters WR.
  assign cfg_src  = (state == IDLE) ? cfg_data : cfg_q;
  assign word_n   = cfg_src[{idx_n, 5'd0} +: 32];
  assign addr_n   = C_BASE_ADDR + AW'({idx_n, 2'b00});

  assign aw_ok    = !awvalid_q || M_AXI_AWREADY;
  assign w_ok     = !wvalid_q || M_AXI_WREADY;
  assign tmo_hit  = (tmo_cnt == TMO);
  assign wr_entry = (state_n == WR) && (state != WR);
  assign rd_entry = (state_n == RD) && (state != RD);
  assign wait_st  = (state == WR) || (state == WRESP) ||
                    (state == RD) || (state == RDATA);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    err_set = 1'b0;
    err_n   = 2'd0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = WR;
          idx_n   = 2'd0;
        end
      end
      WR: begin
        if (aw_ok && w_ok) begin
          state_n = WRESP;
        end else if (tmo_hit) begin
          state_n = FIN;
          err_set = 1'b1;
          err_n   = 2'd3;
        end
      end
      WRESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            state_n = FIN;
            err_set = 1'b1;
            err_n   = 2'd1;
          end else begin
            state_n = ver_q ? RD : NEXT;
          end
        end else if (tmo_hit) begin
          state_n = FIN;
          err_set = 1'b1;
          err_n   = 2'd3;
        end
      end
      RD: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          state_n = RDATA;
        end else if (tmo_hit) begin
          state_n = FIN;
          err_set = 1'b1;
          err_n   = 2'd3;
        end
      end
      RDATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) begin
            state_n = FIN;
            err_set = 1'b1;
            err_n   = 2'd1;
          end else if (M_AXI_RDATA != wdata_q) begin
            state_n = FIN;
            err_set = 1'b1;
            err_n   = 2'd2;
          end else begin
            state_n = NEXT;
          end
        end else if (tmo_hit) begin
          state_n = FIN;
          err_set = 1'b1;
          err_n   = 2'd3;
        end
      end
      NEXT: begin
        if (idx == LAST) begin
          state_n = FIN;
        end else begin
          state_n = WR;
          idx_n   = idx + 2'd1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cfg_q     <= '0;
      ver_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      tmo_cnt   <= '0;
      error     <= 1'b0;
      err_code  <= 2'd0;
      err_index <= 2'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (state == IDLE && start) begin
        cfg_q     <= cfg_data;
        ver_q     <= verify_en;
        error     <= 1'b0;
        err_code  <= 2'd0;
        err_index <= 2'd0;
      end
      if (err_set) begin
        error     <= 1'b1;
        err_code  <= err_n;
        err_index <= idx;
      end
      tmo_cnt <= (wait_st && state_n == state) ?
                 tmo_cnt + 32'd1 : 32'd0;
      // Any exit from WR/RD, including abort, drops the VALIDs.
      if (wr_entry) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        awaddr_q  <= addr_n;
        wdata_q   <= DW'(word_n);
      end else begin
        if (M_AXI_AWREADY || state_n != WR) awvalid_q <= 1'b0;
        if (M_AXI_WREADY || state_n != WR)  wvalid_q  <= 1'b0;
      end
      if (rd_entry) begin
        arvalid_q <= 1'b1;
        araddr_q  <= awaddr_q;
      end else if (M_AXI_ARREADY || state_n != RD) begin
        arvalid_q <= 1'b0;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign done          = (state == FIN);
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state == WRESP);
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state == RDATA);

endmodule

// File: tb/tb_gen_test_pulse_cfg_seq.sv
// tb_gen_test_pulse_cfg_seq: directed bench with a 4-register
// AXI4-Lite slave model and immediate-assertion checks.
module tb_gen_test_pulse_cfg_seq;

  localparam int TMO = 20;
  localparam logic [127:0] CFG1 =
    {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};
  localparam logic [127:0] CFG2 =
    128'h00000044_00000033_00000022_00000011;

  logic         tb_ACLK = 1'b0;
  logic         tb_ARESETN;
  logic         start, verify_en;
  logic [127:0] cfg_data;
  logic         busy, done, error;
  logic [1:0]   err_code, err_index;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready;
  logic         bvalid, bready, arvalid, arready;
  logic         rvalid, rready;
  logic [1:0]   bresp, rresp;

  always #5 tb_ACLK = ~tb_ACLK;

  gen_test_pulse_cfg_seq #(
    .C_TIMEOUT(TMO)
  ) dut (
    .ACLK(tb_ACLK),
    .ARESETN(tb_ARESETN),
    .start(start),
    .verify_en(verify_en),
    .cfg_data(cfg_data),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .err_index(err_index),
    .M_AXI_AWADDR(awaddr),
    .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  int          aw_delay, bad_reg, zero_reg;
  logic        ar_en;
  int          aw_cnt, nwr, nrd, nb;
  logic        aw_have, w_have;
  logic [31:0] aw_a, w_d;
  logic [31:0] mem  [4];
  logic [31:0] wlog [8];

  assign awready = (aw_cnt >= aw_delay);
  assign wready  = 1'b1;
  assign arready = ar_en;

  always @(posedge tb_ACLK or negedge tb_ARESETN) begin
    if (!tb_ARESETN) begin
      aw_cnt  <= 0;
      aw_have <= 1'b0;
      w_have  <= 1'b0;
      aw_a    <= '0;
      w_d     <= '0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      rvalid  <= 1'b0;
      rresp   <= 2'b00;
      rdata   <= '0;
      nwr     <= 0;
      nrd     <= 0;
      nb      <= 0;
    end else begin
      if (awvalid && awready) aw_cnt <= 0;
      else if (awvalid)       aw_cnt <= aw_cnt + 1;
      if (awvalid && awready) begin
        aw_have <= 1'b1;
        aw_a    <= awaddr;
      end
      if (wvalid && wready) begin
        w_have <= 1'b1;
        w_d    <= wdata;
      end
      if (aw_have && w_have && !bvalid) begin
        mem[aw_a[3:2]] <= w_d;
        if (nwr < 8) wlog[nwr] <= aw_a;
        nwr     <= nwr + 1;
        bvalid  <= 1'b1;
        bresp   <= (int'(aw_a[3:2]) == bad_reg) ? 2'b10 : 2'b00;
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        nb     <= nb + 1;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rresp  <= 2'b00;
        rdata  <= (int'(araddr[3:2]) == zero_reg) ?
                  32'd0 : mem[araddr[3:2]];
        nrd    <= nrd + 1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  logic        saw_w_first, proto_err;
  int          ar_cycles, dn_cnt;
  logic        p_awv, p_awr, p_wv, p_wr;
  logic [31:0] p_awa, p_wd;

  always @(posedge tb_ACLK or negedge tb_ARESETN) begin
    if (!tb_ARESETN) begin
      saw_w_first <= 1'b0;
      proto_err   <= 1'b0;
      ar_cycles   <= 0;
      dn_cnt      <= 0;
      p_awv       <= 1'b0;
      p_awr       <= 1'b0;
      p_wv        <= 1'b0;
      p_wr        <= 1'b0;
      p_awa       <= '0;
      p_wd        <= '0;
    end else begin
      if (!wvalid && awvalid) saw_w_first <= 1'b1;
      if (arvalid) ar_cycles <= ar_cycles + 1;
      if (done)    dn_cnt    <= dn_cnt + 1;
      if (p_awv && !p_awr && (!awvalid || awaddr != p_awa))
        proto_err <= 1'b1;
      if (p_wv && !p_wr && (!wvalid || wdata != p_wd))
        proto_err <= 1'b1;
      if (arvalid && (awvalid || wvalid || bready))
        proto_err <= 1'b1;
      if (awvalid && (wstrb != 4'hF || awprot != 3'd0))
        proto_err <= 1'b1;
      p_awv <= awvalid;
      p_awr <= awready;
      p_awa <= awaddr;
      p_wv  <= wvalid;
      p_wr  <= wready;
      p_wd  <= wdata;
    end
  end

  int         total, bad;
  logic       got_done;
  logic [4:0] fin_vr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_vec();
    return {20'd0, busy, done, error, err_code, err_index,
            awvalid, wvalid, bready, arvalid, rready};
  endfunction

  task automatic do_reset();
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b0;
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
  endtask

  task automatic kick(input logic [127:0] c, input logic v);
    @(negedge tb_ACLK);
    cfg_data  = c;
    verify_en = v;
    start     = 1'b1;
    @(negedge tb_ACLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    got_done = 1'b0;
    fin_vr   = '1;
    for (int i = 0; i < limit && !got_done; i++) begin
      @(negedge tb_ACLK);
      if (done) begin
        got_done = 1'b1;
        fin_vr   = {awvalid, wvalid, arvalid, bready, rready};
      end
    end
  endtask

  logic found;

  initial begin
    total      = 0;
    bad        = 0;
    start      = 1'b0;
    verify_en  = 1'b0;
    cfg_data   = '0;
    aw_delay   = 0;
    bad_reg    = -1;
    zero_reg   = -1;
    ar_en      = 1'b1;
    tb_ARESETN = 1'b0;
    found      = 1'b0;

    repeat (3) @(negedge tb_ACLK);
    chk("rst_ctrl", ctrl_vec(), 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    tb_ARESETN = 1'b1;
    repeat (2) @(negedge tb_ACLK);

    // full program + verify, with an ignored start mid-sequence
    kick(CFG1, 1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (5) @(negedge tb_ACLK);
    cfg_data = '0;
    verify_en = 1'b0;
    start = 1'b1;
    @(negedge tb_ACLK);
    start = 1'b0;
    wait_done(500);
    chk("t1_done", 32'(got_done), 32'd1);
    chk("t1_fin_vr", 32'(fin_vr), 32'd0);
    @(negedge tb_ACLK);
    chk("t1_dncnt", 32'(dn_cnt), 32'd1);
    chk("t1_ctrl", ctrl_vec(), 32'd0);
    chk("t1_nwr", 32'(nwr), 32'd4);
    chk("t1_nrd", 32'(nrd), 32'd4);
    chk("t1_addr0", wlog[0], 32'h0);
    chk("t1_addr1", wlog[1], 32'h4);
    chk("t1_addr2", wlog[2], 32'h8);
    chk("t1_addr3", wlog[3], 32'hC);
    chk("t1_mem0", mem[0], 32'h0101FFFF);
    chk("t1_mem3", mem[3], 32'hbeef0011);
    chk("t1_proto", 32'(proto_err), 32'd0);

    // AWREADY late, WREADY early; then start coinciding with done
    do_reset();
    aw_delay = 3;
    kick(CFG2, 1'b0);
    wait_done(500);
    chk("t2_done", 32'(got_done), 32'd1);
    start    = 1'b1;
    cfg_data = '1;
    @(negedge tb_ACLK);
    start = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_err", {30'd0, err_code}, 32'd0);
    chk("t2_wfirst", 32'(saw_w_first), 32'd1);
    chk("t2_nwr", 32'(nwr), 32'd4);
    chk("t2_nb", 32'(nb), 32'd4);
    chk("t2_nrd", 32'(nrd), 32'd0);
    chk("t2_mem2", mem[2], 32'h00000033);
    chk("t2_proto", 32'(proto_err), 32'd0);
    aw_delay = 0;

    // SLVERR on register 2
    do_reset();
    bad_reg = 2;
    kick(CFG1, 1'b1);
    wait_done(500);
    chk("t3_done", 32'(got_done), 32'd1);
    chk("t3_fin_vr", 32'(fin_vr), 32'd0);
    repeat (4) @(negedge tb_ACLK);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_code", {30'd0, err_code}, 32'd1);
    chk("t3_index", {30'd0, err_index}, 32'd2);
    chk("t3_nwr", 32'(nwr), 32'd3);
    chk("t3_last", wlog[2], 32'h8);
    chk("t3_nrd", 32'(nrd), 32'd2);
    bad_reg = -1;

    // readback mismatch on register 1
    do_reset();
    zero_reg = 1;
    kick(CFG1, 1'b1);
    wait_done(500);
    chk("t4_done", 32'(got_done), 32'd1);
    chk("t4_code", {30'd0, err_code}, 32'd2);
    chk("t4_index", {30'd0, err_index}, 32'd1);
    chk("t4_nwr", 32'(nwr), 32'd2);
    zero_reg = -1;

    // ARREADY stuck low
    do_reset();
    ar_en = 1'b0;
    kick(CFG1, 1'b1);
    wait_done(500);
    chk("t5_done", 32'(got_done), 32'd1);
    chk("t5_fin_vr", 32'(fin_vr), 32'd0);
    chk("t5_code", {30'd0, err_code}, 32'd3);
    chk("t5_index", {30'd0, err_index}, 32'd0);
    chk("t5_arcyc", 32'(ar_cycles), 32'(TMO + 1));
    chk("t5_nwr", 32'(nwr), 32'd1);
    ar_en = 1'b1;

    // reset during WRESP of register 1
    do_reset();
    kick(CFG2, 1'b0);
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge tb_ACLK);
      if (bready && awaddr == 32'h4) found = 1'b1;
    end
    chk("t6_reached", 32'(found), 32'd1);
    tb_ARESETN = 1'b0;
    #1;
    chk("t6_rst_ctrl", ctrl_vec(), 32'd0);
    chk("t6_rst_addr", awaddr | araddr, 32'd0);
    chk("t6_rst_wdata", wdata, 32'd0);
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
    repeat (6) @(negedge tb_ACLK);
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_nodone", 32'(dn_cnt), 32'd0);
    chk("t6_nowr", 32'(nwr), 32'd0);
    kick(CFG1, 1'b1);
    wait_done(500);
    chk("t6_done", 32'(got_done), 32'd1);
    chk("t6_first", wlog[0], 32'h0);
    chk("t6_nwr", 32'(nwr), 32'd4);
    chk("t6_err", 32'(error), 32'd0);
    chk("t6_mem1", mem[1], 32'habcd0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
